// File: rtl/fault_ctrl_pkg.sv
// Shared state encoding and default parameters for the fault recovery sequencer.
package fault_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN       = 3'd0,
        ST_FILTER    = 3'd1,
        ST_HALT_WAIT = 3'd2,
        ST_HOLDOFF   = 3'd3,
        ST_RESTART   = 3'd4,
        ST_LOCKOUT   = 3'd5
    } state_e;

    localparam int unsigned DEF_FILTER_CYCLES  = 4;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 16;
    localparam int unsigned DEF_CLEAN_CYCLES   = 64;
    localparam int unsigned DEF_MAX_RETRIES    = 3;
    localparam int unsigned DEF_ACK_TIMEOUT    = 32;
    localparam int unsigned DEF_CNT_W          = 8;

endpackage

// File: rtl/fault_recovery_ctrl_if.sv
// Signals between the fault recovery sequencer and its detector/core environment.
interface fault_recovery_ctrl_if
    import fault_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic               fault_detected;
    logic               core_halted;
    logic               clear_lockout;
    logic               halt_req;
    logic               core_rst;
    logic               lockout;
    logic               irq;
    logic [CNT_W-1:0]   fault_count;
    logic [STATE_W-1:0] state;

    // master is the sequencer side
    modport master (
        input  fault_detected, core_halted, clear_lockout,
        output halt_req, core_rst, lockout, irq, fault_count, state
    );

    modport slave (
        output fault_detected, core_halted, clear_lockout,
        input  halt_req, core_rst, lockout, irq, fault_count, state
    );

endinterface

// File: rtl/persist_counter.sv
// Consecutive-cycle counter: counts enabled cycles with cond high, drops to 0 when cond is low.
// done is a lookahead flag: high on the cycle whose edge brings the count to TERMINAL.
module persist_counter #(
    parameter int unsigned TERMINAL = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic cond,
    output logic done
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] cnt;

    // saturates at TERMINAL so a stalled caller never sees a wrap
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (!cond) begin
                cnt <= '0;
            end else if (cnt < TERM) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign done = enable && cond && (cnt >= LAST);

endmodule

// File: rtl/fault_recovery_ctrl.sv
// Supervisory sequencer: qualifies faults, halts the core, waits for a clean supply,
// restarts the core, and escalates repeated episodes to a software-cleared lockout.
module fault_recovery_ctrl
    import fault_ctrl_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int unsigned CLEAN_CYCLES   = DEF_CLEAN_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input logic                   clk,
    input logic                   reset,
    fault_recovery_ctrl_if.master bus
);

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] fault_count_q, fault_count_nxt;
    logic [CNT_W-1:0] retry_q, retry_nxt;
    logic             halt_req_q, halt_req_nxt;
    logic             core_rst_q, core_rst_nxt;
    logic             lockout_q, lockout_nxt;
    logic             irq_q, irq_nxt;

    logic in_filt_win, in_run, in_halt_wait, in_holdoff;
    logic filt_done, clean_done, ack_done, hold_done;

    assign in_run       = (state_q == ST_RUN);
    assign in_filt_win  = (state_q == ST_RUN) || (state_q == ST_FILTER);
    assign in_halt_wait = (state_q == ST_HALT_WAIT);
    assign in_holdoff   = (state_q == ST_HOLDOFF);

    persist_counter #(.TERMINAL(FILTER_CYCLES), .CNT_W(CNT_W)) u_filt (
        .clk(clk), .reset(reset), .enable(in_filt_win), .clear(!in_filt_win),
        .cond(bus.fault_detected), .done(filt_done)
    );

    persist_counter #(.TERMINAL(CLEAN_CYCLES), .CNT_W(CNT_W)) u_clean (
        .clk(clk), .reset(reset), .enable(in_run), .clear(!in_run),
        .cond(!bus.fault_detected), .done(clean_done)
    );

    persist_counter #(.TERMINAL(ACK_TIMEOUT), .CNT_W(CNT_W)) u_ack (
        .clk(clk), .reset(reset), .enable(in_halt_wait), .clear(!in_halt_wait),
        .cond(!bus.core_halted), .done(ack_done)
    );

    persist_counter #(.TERMINAL(HOLDOFF_CYCLES), .CNT_W(CNT_W)) u_hold (
        .clk(clk), .reset(reset), .enable(in_holdoff), .clear(!in_holdoff),
        .cond(!bus.fault_detected), .done(hold_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            fault_count_q <= '0;
            retry_q       <= '0;
            halt_req_q    <= 1'b0;
            core_rst_q    <= 1'b0;
            lockout_q     <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            fault_count_q <= fault_count_nxt;
            retry_q       <= retry_nxt;
            halt_req_q    <= halt_req_nxt;
            core_rst_q    <= core_rst_nxt;
            lockout_q     <= lockout_nxt;
            irq_q         <= irq_nxt;
        end
    end

    // next state, episode bookkeeping and next-cycle outputs
    always_comb begin
        state_nxt       = state_q;
        retry_nxt       = retry_q;
        fault_count_nxt = fault_count_q;

        case (state_q)
            ST_RUN: begin
                if (filt_done) begin
                    state_nxt = ST_HALT_WAIT;
                end else if (bus.fault_detected) begin
                    state_nxt = ST_FILTER;
                end
                if (clean_done) begin
                    retry_nxt = '0;
                end
            end
            ST_FILTER: begin
                if (!bus.fault_detected) begin
                    state_nxt = ST_RUN;
                end else if (filt_done) begin
                    state_nxt = ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                // an ack on the timeout cycle still counts as an ack
                if (bus.core_halted) begin
                    state_nxt = (retry_q > CNT_W'(MAX_RETRIES)) ? ST_LOCKOUT : ST_HOLDOFF;
                end else if (ack_done) begin
                    state_nxt = ST_LOCKOUT;
                end
            end
            ST_HOLDOFF: begin
                if (hold_done) begin
                    state_nxt = ST_RESTART;
                end
            end
            ST_RESTART: begin
                state_nxt = ST_RUN;
            end
            ST_LOCKOUT: begin
                if (bus.clear_lockout && !bus.fault_detected) begin
                    state_nxt = ST_RESTART;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        if ((state_nxt == ST_HALT_WAIT) && (state_q != ST_HALT_WAIT)) begin
            if (fault_count_q != '1) begin
                fault_count_nxt = fault_count_q + CNT_W'(1);
            end
            if (retry_nxt != '1) begin
                retry_nxt = retry_nxt + CNT_W'(1);
            end
        end

        halt_req_nxt = (state_nxt != ST_RUN) && (state_nxt != ST_FILTER);
        core_rst_nxt = (state_nxt == ST_RESTART);
        lockout_nxt  = (state_nxt == ST_LOCKOUT);
        irq_nxt      = (state_nxt != state_q) &&
                       ((state_nxt == ST_HALT_WAIT) || (state_nxt == ST_LOCKOUT));
    end

    assign bus.state       = state_q;
    assign bus.fault_count = fault_count_q;
    assign bus.halt_req    = halt_req_q;
    assign bus.core_rst    = core_rst_q;
    assign bus.lockout     = lockout_q;
    assign bus.irq         = irq_q;

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Self-checking bench for fault_recovery_ctrl: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_fault_recovery_ctrl;
    import fault_ctrl_pkg::*;

    localparam int unsigned CW = DEF_CNT_W;
    localparam int unsigned VW = STATE_W + 4 + CW;

    localparam int FC  = int'(DEF_FILTER_CYCLES);
    localparam int HC  = int'(DEF_HOLDOFF_CYCLES);
    localparam int CC  = int'(DEF_CLEAN_CYCLES);
    localparam int MR  = int'(DEF_MAX_RETRIES);
    localparam int AT  = int'(DEF_ACK_TIMEOUT);
    localparam int SAT = (1 << CW) - 1;

    localparam int M_RUN = 0, M_FILTER = 1, M_HW = 2, M_HOLD = 3, M_RESTART = 4, M_LOCK = 5;

    logic clk = 1'b0;
    logic reset;

    fault_recovery_ctrl_if #(.CNT_W(CW)) bus ();

    fault_recovery_ctrl #(
        .FILTER_CYCLES(DEF_FILTER_CYCLES), .HOLDOFF_CYCLES(DEF_HOLDOFF_CYCLES),
        .CLEAN_CYCLES(DEF_CLEAN_CYCLES), .MAX_RETRIES(DEF_MAX_RETRIES),
        .ACK_TIMEOUT(DEF_ACK_TIMEOUT), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int irq_seen = 0;

    typedef struct {
        bit            f, h, c, r;
        logic [VW-1:0] exp;
    } vec_t;

    vec_t tbl[$];

    // behavioural model state
    int m_mode, m_filt, m_hold, m_clean, m_ack, m_retry, m_episodes;
    bit m_irq;
    logic [VW-1:0] m_vec;

    function automatic logic [VW-1:0] pack_out(input int st, input bit halt, input bit rst,
                                               input bit lock, input bit irq, input int fc);
        return {STATE_W'(st), halt, rst, lock, irq, CW'(fc)};
    endfunction

    function automatic vec_t mk(input bit f, input bit h, input bit c, input bit r,
                                input int st, input bit halt, input bit rst,
                                input bit lock, input bit irq, input int fc);
        vec_t v;
        v.f = f; v.h = h; v.c = c; v.r = r;
        v.exp = pack_out(st, halt, rst, lock, irq, fc);
        return v;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.state, bus.halt_req, bus.core_rst, bus.lockout, bus.irq, bus.fault_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one clock of the specified rules to the model and forms the expected outputs.
    task automatic model_step(input bit f, input bit h, input bit c, input bit r);
        int nm;
        if (r) begin
            m_mode = M_RUN; m_filt = 0; m_hold = 0; m_clean = 0; m_ack = 0;
            m_retry = 0; m_episodes = 0; m_irq = 1'b0;
        end else begin
            nm = m_mode;
            case (m_mode)
                M_RUN: begin
                    if (f) begin
                        m_clean = 0;
                        m_filt  = 1;
                        nm = (m_filt >= FC) ? M_HW : M_FILTER;
                    end else begin
                        m_filt = 0;
                        if (m_clean < CC) m_clean++;
                        if (m_clean == CC) m_retry = 0;
                    end
                end
                M_FILTER: begin
                    if (!f) nm = M_RUN;
                    else begin
                        m_filt++;
                        if (m_filt >= FC) nm = M_HW;
                    end
                end
                M_HW: begin
                    m_ack++;
                    if (h) nm = (m_retry > MR) ? M_LOCK : M_HOLD;
                    else if (m_ack >= AT) nm = M_LOCK;
                end
                M_HOLD: begin
                    if (f) m_hold = 0;
                    else begin
                        m_hold++;
                        if (m_hold >= HC) nm = M_RESTART;
                    end
                end
                M_RESTART: nm = M_RUN;
                M_LOCK: begin
                    if (c && !f) begin
                        nm = M_RESTART;
                        m_retry = 0;
                    end
                end
                default: nm = M_RUN;
            endcase
            m_irq = (nm != m_mode) && (nm == M_HW || nm == M_LOCK);
            if (nm == M_HW && m_mode != M_HW) begin
                if (m_episodes < SAT) m_episodes++;
                if (m_retry < SAT) m_retry++;
            end
            if (nm != m_mode) begin
                if (nm == M_RUN) begin m_filt = 0; m_clean = 0; end
                if (nm == M_HW) m_ack = 0;
                if (nm == M_HOLD) m_hold = 0;
            end
            m_mode = nm;
        end
        m_vec = pack_out(m_mode, (m_mode >= M_HW), (m_mode == M_RESTART),
                         (m_mode == M_LOCK), m_irq, m_episodes);
    endtask

    task automatic drive(input bit f, input bit h, input bit c, input bit r);
        bus.fault_detected = f;
        bus.core_halted    = h;
        bus.clear_lockout  = c;
        reset              = r;
    endtask

    task automatic step(input bit f, input bit h, input bit c, input bit r, input string name);
        drive(f, h, c, r);
        model_step(f, h, c, r);
        @(posedge clk);
        #1;
        check(name, 32'(dut_vec()), 32'(m_vec));
        irq_seen += int'(bus.irq);
    endtask

    task automatic qualify(input string tag);
        for (int i = 0; i < FC; i++) step(1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic recover(input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, tag);
        for (int i = 0; i < HC; i++) step(1'b0, 1'b1, 1'b0, 1'b0, tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic run_table();
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 2,1,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 2,1,0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 3,1,0,0,0,1));
        for (int i = 0; i < 15; i++) tbl.push_back(mk(0,1,0,0, 3,1,0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 4,1,1,0,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0, 2,1,0,0,1,2));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].f, tbl[i].h, tbl[i].c, tbl[i].r);
            model_step(tbl[i].f, tbl[i].h, tbl[i].c, tbl[i].r);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end
    endtask

    task automatic run_directed();
        int n;
        // fault pulse mid-holdoff restarts the holdoff window
        step(0, 0, 0, 1, "hold_reset");
        qualify("hold_q");
        step(0, 1, 0, 0, "hold_ack");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, "hold_run");
        step(1, 1, 0, 0, "hold_pulse");
        check("hold_after_pulse", 32'(bus.state), 32'(M_HOLD));
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 1, 0, 0, "hold_wait");
            if (bus.state == 3'd4) begin n = i; break; end
        end
        check("hold_restart_delay", 32'(n), 32'(HC));
        step(0, 0, 0, 0, "hold_run_again");

        // escalation to lockout, then software clear
        step(0, 0, 0, 1, "esc_reset");
        for (int e = 0; e < 3; e++) begin
            qualify("esc_q");
            recover("esc_rec");
            for (int i = 0; i < 10; i++) step(0, 0, 0, 0, "esc_clean");
        end
        irq_seen = 0;
        qualify("esc_q4");
        step(0, 1, 0, 0, "esc_ack4");
        step(0, 1, 0, 0, "esc_settle");
        check("esc_irq_pulses", 32'(irq_seen), 32'(2));
        check("esc_state", 32'(bus.state), 32'(M_LOCK));
        check("esc_lockout", 32'(bus.lockout), 32'(1));
        check("esc_fault_count", 32'(bus.fault_count), 32'(4));
        step(1, 1, 1, 0, "clr_with_fault");
        check("clr_with_fault_state", 32'(bus.state), 32'(M_LOCK));
        step(0, 1, 1, 0, "clr_clean");
        check("clr_restart", 32'({bus.state, bus.core_rst}), 32'({3'd4, 1'b1}));
        step(0, 0, 0, 0, "clr_run");
        check("clr_run_halt", 32'({bus.state, bus.halt_req}), 32'(0));
        qualify("post_clr_q");
        step(0, 1, 0, 0, "post_clr_ack");
        check("post_clr_holdoff", 32'(bus.state), 32'(M_HOLD));
        for (int i = 0; i < HC; i++) step(0, 1, 0, 0, "post_clr_hold");
        step(0, 0, 0, 0, "post_clr_run");
        check("post_clr_count", 32'({bus.state, bus.fault_count}), 32'({3'd0, 8'd5}));

        // ack timeout forces lockout
        step(0, 0, 0, 1, "to_reset");
        qualify("to_q");
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0, "to_wait");
            if (bus.state == 3'd5) begin n = i; break; end
        end
        check("ack_timeout_cycles", 32'(n), 32'(AT));

        // ack on the timeout cycle wins, then reset mid-holdoff
        step(0, 0, 0, 1, "ackto_reset");
        qualify("ackto_q");
        for (int i = 0; i < AT - 1; i++) step(0, 0, 0, 0, "ackto_wait");
        step(0, 1, 0, 0, "ackto_ack");
        check("ack_on_timeout", 32'(bus.state), 32'(M_HOLD));
        step(0, 1, 0, 0, "pre_reset_hold");
        step(0, 1, 0, 1, "reset_in_holdoff");
        check("reset_in_holdoff_all", 32'(dut_vec()), 32'(0));
    endtask

    task automatic run_random();
        int pf, ph, pc;
        bit f, h, c, r;
        step(0, 0, 0, 1, "rnd_reset");
        for (int b = 0; b < 60; b++) begin
            case ($urandom_range(0, 3))
                0:       pf = 0;
                1:       pf = 3;
                2:       pf = 40;
                default: pf = 95;
            endcase
            case ($urandom_range(0, 2))
                0:       ph = 0;
                1:       ph = 10;
                default: ph = 60;
            endcase
            pc = 20;
            for (int i = 0; i < 50; i++) begin
                f = ($urandom_range(0, 99) < pf);
                h = ($urandom_range(0, 99) < ph);
                c = ($urandom_range(0, 99) < pc);
                r = ($urandom_range(0, 999) < 3);
                step(f, h, c, r, "rnd");
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        model_step(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("reset_state", 32'(dut_vec()), 32'(0));
        run_table();
        run_directed();
        run_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fault_recovery_ctrl.md
Name: fault_recovery_ctrl

Overview:
Supervisory sequencer between fault_detector and core. It qualifies the raw fault_detected flag, halts the core with a request/acknowledge handshake, and waits for the supply to stay fault-free before restarting the core. Repeated fault episodes inside a clean window escalate to a latched lockout that only software can clear.

Parameters:
FILTER_CYCLES, 4, consecutive fault_detected=1 cycles required to qualify a fault (min 1)
HOLDOFF_CYCLES, 16, consecutive fault-free cycles required before restart (min 1)
CLEAN_CYCLES, 64, consecutive fault-free cycles in RUN that clear the retry count
MAX_RETRIES, 3, episodes tolerated per clean window; episode MAX_RETRIES+1 locks out
ACK_TIMEOUT, 32, cycles allowed for core_halted after halt_req, before forced lockout
CNT_W, 8, width of internal counters and of fault_count

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
fault_detected  in  1  raw flag from fault_detector
core_halted  in  1  halt acknowledge from core (level)
clear_lockout  in  1  software clear, sampled only in LOCKOUT
halt_req  out  1  request core to halt
core_rst  out  1  one-cycle core restart pulse
lockout  out  1  high while in LOCKOUT
irq  out  1  one-cycle event pulse
fault_count  out  CNT_W  qualified episodes since reset, saturating
state  out  3  current state encoding

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset (any state, mid-operation included): next edge state=RUN. halt_req, core_rst, lockout and irq = 0. fault_count, retry_cnt and all counters = 0.
- State encodings: RUN=0, FILTER=1, HALT_WAIT=2, HOLDOFF=3, RESTART=4, LOCKOUT=5. Outputs are registered; all transitions take one edge.
- RUN: halt_req=0.
  - fault=1 -> FILTER with filt_cnt=1. If FILTER_CYCLES=1, go directly to HALT_WAIT.
  - Each fault-free cycle increments clean_cnt. At CLEAN_CYCLES, retry_cnt=0 and clean_cnt holds.
  - fault=1 clears clean_cnt; retry_cnt is untouched.
- FILTER: fault=1 increments filt_cnt. Reaching FILTER_CYCLES -> HALT_WAIT. fault=0 -> RUN, with no count and no irq (glitch rejected).
- Entry to HALT_WAIT: fault_count+1 (saturating at all-ones), retry_cnt+1 (saturating), irq pulse.
- HALT_WAIT: halt_req=1, ack_cnt counts.
  - core_halted=1 and retry_cnt>MAX_RETRIES -> LOCKOUT.
  - core_halted=1 otherwise -> HOLDOFF.
  - ack_cnt reaches ACK_TIMEOUT without ack -> LOCKOUT.
- HOLDOFF: halt_req=1. hold_cnt increments on fault=0 and clears to 0 on any fault=1. Reaching HOLDOFF_CYCLES -> RESTART.
- RESTART: halt_req=1 and core_rst=1 for exactly one cycle, then RUN (halt_req=0 the following cycle). fault is ignored in RESTART; the filter restarts in RUN.
- LOCKOUT: halt_req=1, lockout=1, irq pulses on entry.
  - clear_lockout=1 with fault=0 -> RESTART and retry_cnt=0.
  - clear_lockout=1 with fault=1 is ignored. clear_lockout in any other state is ignored.
- Simultaneous events:
  - reset beats everything.
  - In HALT_WAIT, an ack arriving on the timeout cycle counts as ack.
  - In RUN, fault on the cycle clean_cnt would expire: fault wins.
- Counters (filt, hold, clean, ack) never wrap; each saturates at its terminal value.

Decomposition:
- Package fault_ctrl_pkg holds:
  - state enum typedef with the encodings above
  - state width constant
  - default parameter constants shared with tb
- One sub-module, persist_counter: consecutive-cycle counter with inputs enable, clear, cond and a terminal count parameter, output done. It is instantiated for the filter, holdoff, clean-window and ack-timeout counts.

Test Plan:
- fault=1 for 3 cycles, then 0 -> state returns to RUN; halt_req=0, irq=0, fault_count=0.
- fault=1 for 4 cycles, core_halted after 2 cycles, fault=0 thereafter -> HALT_WAIT, HOLDOFF, then 16 cycles later RESTART. core_rst pulses 1 cycle, state RUN, fault_count=1, one irq.
- Fault pulse at hold_cnt=10 during HOLDOFF -> hold_cnt restarts; RESTART occurs 16 fault-free cycles after the pulse.
- Four qualified episodes, each separated by fewer than 64 clean RUN cycles -> 4th episode enters LOCKOUT after ack; lockout=1, fault_count=4, two irq pulses in that episode.
- clear_lockout with fault=1 -> stays in LOCKOUT. clear_lockout with fault=0 -> RESTART, then RUN; retry_cnt=0, so the next single episode recovers normally.
- core_halted held 0 for 32 cycles in HALT_WAIT -> LOCKOUT. Separately, reset asserted in HOLDOFF -> next edge RUN with all outputs and fault_count at 0.
